inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Runtime writer for the instruction memory: receives a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit instruction words, and issues one-cycle word writes into the instruction store.
- Holds the core (cpu_hold_o) for the entire load, so the fetch path never sees partially loaded contents.
- Sits between the serial byte source and the instruction memory write port.

Parameters:
- CPU_WIDTH, 32, instruction/data word width; fixed at 32, byte assembly assumes 4 bytes per word.
- INST_MEM_ADDR_DEPTH, 1024, number of words in the instruction store.
- ADDR_W, 10, word-index width; must satisfy 2**ADDR_W >= INST_MEM_ADDR_DEPTH.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- load_start_i  input  1  single-cycle pulse that begins a load; ignored unless in IDLE.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle; transfer occurs when valid && ready.
- wr_en_o  output  1  instruction memory write strobe, one cycle per word.
- wr_addr_o  output  ADDR_W  word index (0-based; byte PC offset = index*4).
- wr_data_o  output  CPU_WIDTH  assembled instruction word.
- cpu_hold_o  output  1  keeps the core stalled/in reset while loading.
- done_o  output  1  one-cycle pulse at end of load (success or error).
- err_o  output  1  sticky length error; cleared by the next accepted load_start_i or by reset.

Behaviour:
- Reset: state=IDLE. All outputs 0: byte_ready_o, wr_en_o, wr_addr_o, wr_data_o, cpu_hold_o, done_o, err_o. Internal len, byte_cnt and word_idx are 0.
- Reset mid-load: return to IDLE with no further writes. Words already written stay in memory.
- Stream format: 2-byte word count LEN (low byte first), then LEN words of 4 bytes each, least significant byte first.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE.
- IDLE:
  - byte_ready_o=0, cpu_hold_o=0.
  - load_start_i=1 → LEN_LO; clear err_o.
- LEN_LO:
  - byte_ready_o=1.
  - On transfer: len[7:0]=byte → LEN_HI.
- LEN_HI:
  - byte_ready_o=1.
  - On transfer: len[15:8]=byte, then the next state is decided on the full 16-bit value:
    - LEN==0 → DONE.
    - LEN > INST_MEM_ADDR_DEPTH → set err_o, → DONE.
    - Otherwise → DATA with byte_cnt=0, word_idx=0.
- DATA:
  - byte_ready_o=1.
  - On transfer: place byte at bits [8*byte_cnt+7 : 8*byte_cnt] of the assembly register; byte_cnt++.
  - Transfer with byte_cnt==3 → WRITE, byte_cnt wraps to 0.
  - Bytes with byte_valid_i=0 stall without timeout; no state change.
- WRITE:
  - byte_ready_o=0, wr_en_o=1, wr_addr_o=word_idx, wr_data_o=assembled word.
  - Exactly one cycle.
  - Then word_idx++. If word_idx+1==LEN → DONE, else → DATA.
- DONE:
  - done_o=1 for one cycle, cpu_hold_o still 1 → IDLE.
- cpu_hold_o timing: 1 in every state except IDLE. It rises the cycle after load_start_i and falls the cycle after DONE.
- Latency: 4th byte of a word accepted at edge k → wr_en_o high in cycle k+1. Next byte can be accepted from cycle k+2. Throughput is at most 1 word per 5 cycles.
- byte_valid_i in IDLE or WRITE: not accepted (ready=0). The source must hold the byte.
- load_start_i in any non-IDLE state: ignored; no restart, err_o unaffected.
- wr_addr_o and wr_data_o hold their last values outside WRITE. Only wr_en_o qualifies them.
- Excess bytes after LEN words are not consumed (loader is in IDLE with ready=0).

Test Plan:
- Basic load: start pulse; stream 02 00, then EF BE AD DE, then 13 00 00 00.
  - Required: wr_en_o twice: (addr 0, 0xDEADBEEF), then (addr 1, 0x00000013).
  - done_o pulses 1 cycle after the 2nd write; cpu_hold_o high from start+1 through the done cycle; err_o=0.
- Backpressure/gaps: same stream with byte_valid_i low for 3 random cycles between every byte.
  - Identical writes; no byte lost or duplicated.
  - Each wr_en_o exactly 1 cycle after the 4th byte's transfer.
- Zero length: stream 00 00 → no wr_en_o; done_o one cycle after LEN_HI transfer; err_o=0.
- Oversize: stream 01 04 (LEN=1025) → err_o=1 and done_o pulse with no writes.
  - err_o stays 1 in IDLE; cleared by the next load_start_i.
  - Boundary: LEN=1024 loads 1024 words, last address 1023, err_o=0.
- Start while busy: load_start_i pulsed during DATA → ignored; load completes normally with correct addresses.
- Reset mid-load: rst_i after 1.5 words → next cycle all outputs 0 and state IDLE.
  - A fresh load afterwards starts again at address 0.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Runtime instruction-memory loader: turns a length-prefixed little-endian byte
// stream into one-cycle word writes, holding the core for the whole load.
module inst_mem_loader #(
  parameter int CPU_WIDTH           = 32,
  parameter int INST_MEM_ADDR_DEPTH = 1024,
  parameter int ADDR_W              = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_start_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic                 byte_ready_o,
  output logic                 wr_en_o,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [CPU_WIDTH-1:0] wr_data_o,
  output logic                 cpu_hold_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE
  } state_t;

  localparam logic [15:0] DEPTH_L = 16'(INST_MEM_ADDR_DEPTH);

  state_t                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]      word_idx_q, word_idx_d;
  logic [23:0]            asm_q, asm_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [CPU_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                   err_q, err_d;
  logic                   xfer;
  logic [15:0]            full_len;

  assign byte_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA);
  assign xfer         = byte_valid_i && byte_ready_o;
  assign full_len     = {byte_data_i, len_q[7:0]};

  assign wr_en_o    = (state_q == S_WRITE);
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign cpu_hold_o = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = err_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    asm_d      = asm_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (load_start_i) begin
          err_d   = 1'b0;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_data_i;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_data_i;
          byte_cnt_d  = 2'd0;
          word_idx_d  = '0;
          if (full_len == 16'd0) begin
            state_d = S_DONE;
          end else if (full_len > DEPTH_L) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Output registers are loaded here so they stay stable after WRITE.
            wr_data_d = {byte_data_i, asm_q};
            wr_addr_d = word_idx_q;
            state_d   = S_WRITE;
          end else begin
            asm_d[8*byte_cnt_q +: 8] = byte_data_i;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        if (16'(word_idx_q) + 16'd1 == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      asm_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      asm_q      <= asm_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: the driver queues the writes and done
// pulses a length-prefixed stream should produce; a monitor pops and compares.
module tb_inst_mem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              load_start_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              cpu_hold_o;
  logic              done_o;
  logic              err_o;

  inst_mem_loader #(
    .CPU_WIDTH(32), .INST_MEM_ADDR_DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_start_i(load_start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .cpu_hold_o(cpu_hold_o), .done_o(done_o),
    .err_o(err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int addr; logic [31:0] data; int at; } wr_exp_t;
  typedef struct { logic err; int at; } done_exp_t;

  wr_exp_t     wr_q[$];
  done_exp_t   done_q[$];
  logic [31:0] stim_words [0:DEPTH-1];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i) begin
      if (wr_en_o) begin
        check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          wr_exp_t e;
          e = wr_q.pop_front();
          check("wr_addr", 64'(wr_addr_o), 64'(e.addr));
          check("wr_data", 64'(wr_data_o), 64'(e.data));
          check("wr_cycle", 64'(cyc), 64'(e.at));
          check("wr_hold", 64'(cpu_hold_o), 64'd1);
        end
      end
      if (done_o) begin
        check("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) begin
          done_exp_t d;
          d = done_q.pop_front();
          check("done_err", 64'(err_o), 64'(d.err));
          check("done_cycle", 64'(cyc), 64'(d.at));
          check("done_hold", 64'(cpu_hold_o), 64'd1);
        end
      end
    end
  end

  // Drives one byte from a negedge; expectations are queued once the
  // transfer on the coming rising edge is certain.
  task automatic send_byte(input logic [7:0] b, input int gap,
                           input bit push_wr, input int addr, input logic [31:0] data,
                           input bit push_done, input bit derr, input int ddly);
    int n;
    byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    n = 0;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) begin
      check("byte_accept_timeout", 64'(byte_ready_o), 64'd1);
      byte_valid_i = 1'b0;
      return;
    end
    if (push_wr) wr_q.push_back('{addr: addr, data: data, at: cyc + 1});
    if (push_done) done_q.push_back('{err: derr, at: cyc + ddly});
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk_i);
    check("hold_before_start", 64'(cpu_hold_o), 64'd0);
    load_start_i = 1'b1;
    @(negedge clk_i);
    load_start_i = 1'b0;
    check("hold_after_start", 64'(cpu_hold_o), 64'd1);
    check("err_cleared", 64'(err_o), 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cpu_hold_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("idle_reached", 64'(cpu_hold_o), 64'd0);
  endtask

  // Reference behaviour: LEN in 1..DEPTH writes word i to address i, then done
  // one cycle after the last write; LEN 0 or oversize gives done straight after
  // the length bytes (err only when oversize) and no writes.
  task automatic run_load(input int len, input int gmax, input bit inject, input int stop_after_bytes);
    int          nwords;
    bit          oversize;
    logic [15:0] l16;
    int          sent;
    l16      = 16'(len);
    oversize = (len > DEPTH);
    nwords   = oversize ? 0 : len;
    start_load();
    send_byte(l16[7:0], $urandom_range(0, gmax), 0, 0, 0, 0, 0, 0);
    send_byte(l16[15:8], $urandom_range(0, gmax), 0, 0, 0, nwords == 0, oversize, 1);
    sent = 0;
    for (int i = 0; i < nwords; i++) begin
      logic [31:0] w;
      w = stim_words[i];
      for (int b = 0; b < 4; b++) begin
        if (stop_after_bytes >= 0 && sent == stop_after_bytes) return;
        send_byte(w[8*b +: 8], $urandom_range(0, gmax), b == 3, i, w,
                  (b == 3) && (i == nwords - 1), 1'b0, 2);
        sent++;
      end
      if (inject && i == 0) begin
        @(negedge clk_i);
        load_start_i = 1'b1;
        @(negedge clk_i);
        load_start_i = 1'b0;
      end
    end
    wait_idle();
    check("err_after_load", 64'(err_o), 64'(oversize));
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) stim_words[i] = $urandom;
  endtask

  initial begin
    rst_i = 1'b1;
    load_start_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (3) @(negedge clk_i);
    check("rst_ready", 64'(byte_ready_o), 64'd0);
    check("rst_wr_en", 64'(wr_en_o), 64'd0);
    check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
    check("rst_wr_data", 64'(wr_data_o), 64'd0);
    check("rst_hold", 64'(cpu_hold_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    rst_i = 1'b0;

    stim_words[0] = 32'hDEADBEEF;
    stim_words[1] = 32'h00000013;
    run_load(2, 0, 0, -1);
    $display("basic load done at cycle %0d", cyc);
    run_load(2, 3, 0, -1);
    $display("gapped load done at cycle %0d", cyc);

    run_load(0, 0, 0, -1);
    $display("zero-length load done at cycle %0d", cyc);
    run_load(1025, 0, 0, -1);
    repeat (3) @(negedge clk_i);
    check("err_sticky_idle", 64'(err_o), 64'd1);
    check("idle_ready", 64'(byte_ready_o), 64'd0);
    $display("oversize load done at cycle %0d", cyc);

    fill_random(DEPTH);
    run_load(DEPTH, 0, 0, -1);
    $display("full-depth load done at cycle %0d", cyc);

    fill_random(4);
    run_load(4, 1, 1, -1);
    $display("start-while-busy load done at cycle %0d", cyc);

    for (int t = 0; t < 6; t++) begin
      int len;
      len = $urandom_range(1, 12);
      fill_random(len);
      run_load(len, 3, 0, -1);
      $display("random load %0d len=%0d done at cycle %0d", t, len, cyc);
    end

    fill_random(4);
    run_load(4, 1, 0, 6);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_ready", 64'(byte_ready_o), 64'd0);
    check("mid_rst_wr_en", 64'(wr_en_o), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr_o), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data_o), 64'd0);
    check("mid_rst_hold", 64'(cpu_hold_o), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    rst_i = 1'b0;
    $display("reset mid-load at cycle %0d", cyc);
    fill_random(3);
    run_load(3, 2, 0, -1);
    $display("post-reset load done at cycle %0d", cyc);

    repeat (5) @(negedge clk_i);
    check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    check("done_queue_drained", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
